// File: rtl/mem_access_arbiter.sv
// Arbitrates the byte-wide data memory between instruction fetch and load/store,
// sequencing each word access as four little-endian byte beats.
module mem_access_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int LS_FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic              ls_width,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic              owner_ls, last_ls, lat_we, lat_byte;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       lat_wdata, asm_q, asm_nxt, rdata_nxt;
    logic [1:0]        beat_cnt;
    logic              any_req, pick_ls, last_beat;

    assign any_req   = if_req | ls_req;
    // last_ls low means IF won the last tie, so LS takes the next one
    assign pick_ls   = ls_req & (~if_req | (LS_FIXED_PRIO != 0) | ~last_ls);
    assign last_beat = lat_byte | (beat_cnt == 2'd3);
    assign busy      = (state != IDLE);
    assign mem_addr  = addr_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_done   = 1'b0;
        ls_done   = 1'b0;
        asm_nxt   = asm_q;
        case (state)
            IDLE: if (any_req) state_nxt = BEAT;
            BEAT: begin
                mem_we    = lat_we;
                mem_wdata = lat_wdata[{beat_cnt, 3'b000} +: 8];
                if_gnt    = (beat_cnt == 2'd0) & ~owner_ls;
                ls_gnt    = (beat_cnt == 2'd0) & owner_ls;
                if (!lat_we) asm_nxt[{beat_cnt, 3'b000} +: 8] = mem_rdata;
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                if_done   = ~owner_ls;
                ls_done   = owner_ls;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        rdata_nxt = lat_byte ? {24'd0, asm_nxt[7:0]} : asm_nxt;
    end

    // rdata is written on the last beat edge so it is already valid in the done cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_ls  <= 1'b0;
            last_ls   <= 1'b0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_wdata <= 32'd0;
            addr_q    <= '0;
            beat_cnt  <= 2'd0;
            asm_q     <= 32'd0;
            if_rdata  <= 32'd0;
            ls_rdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner_ls  <= pick_ls;
                    if ((LS_FIXED_PRIO == 0) && if_req && ls_req) last_ls <= pick_ls;
                    addr_q    <= pick_ls ? ls_addr : if_addr;
                    lat_we    <= pick_ls & ls_we;
                    lat_byte  <= pick_ls & ls_width;
                    lat_wdata <= pick_ls ? ls_wdata : 32'd0;
                    beat_cnt  <= 2'd0;
                    asm_q     <= 32'd0;
                end
                BEAT: begin
                    asm_q    <= asm_nxt;
                    beat_cnt <= beat_cnt + 2'd1;
                    if (last_beat) begin
                        if (owner_ls) ls_rdata <= rdata_nxt;
                        else          if_rdata <= rdata_nxt;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_access_arbiter;
    localparam int AW = 32;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    logic          if_req, ls_req, ls_we, ls_width;
    logic [AW-1:0] if_addr, ls_addr, mem_addr;
    logic [31:0]   ls_wdata, if_rdata, ls_rdata;
    logic          if_gnt, if_done, ls_gnt, ls_done, mem_we, busy;
    logic [7:0]    mem_wdata, mem_rdata;

    logic          fp_if_req, fp_ls_req, fp_ls_we, fp_ls_width;
    logic [AW-1:0] fp_if_addr, fp_ls_addr, fp_mem_addr;
    logic [31:0]   fp_ls_wdata, fp_if_rdata, fp_ls_rdata;
    logic          fp_if_gnt, fp_if_done, fp_ls_gnt, fp_ls_done, fp_mem_we, fp_busy;
    logic [7:0]    fp_mem_wdata, fp_mem_rdata;

    logic [7:0] mem [256];
    logic       load_mem = 1'b0;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) % 256);
    endfunction

    always @(posedge clock) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata    = mem[mem_addr[7:0]];
    assign fp_mem_rdata = fp_mem_addr[7:0] ^ 8'h3C;

    mem_access_arbiter #(.ADDR_W(AW), .LS_FIXED_PRIO(0)) dut (
        .clock(clock), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_width(ls_width), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_access_arbiter #(.ADDR_W(AW), .LS_FIXED_PRIO(1)) dut_fp (
        .clock(clock), .resetn(resetn),
        .if_req(fp_if_req), .if_addr(fp_if_addr), .if_gnt(fp_if_gnt), .if_done(fp_if_done),
        .if_rdata(fp_if_rdata),
        .ls_req(fp_ls_req), .ls_we(fp_ls_we), .ls_width(fp_ls_width), .ls_addr(fp_ls_addr),
        .ls_wdata(fp_ls_wdata), .ls_gnt(fp_ls_gnt), .ls_done(fp_ls_done), .ls_rdata(fp_ls_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we), .mem_rdata(fp_mem_rdata),
        .busy(fp_busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        bit          is_ls;
        bit          we;
        bit          byte_w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v, input int idx);
        int          gcyc, dcyc;
        logic [31:0] rd;
        logic [31:0] wa [$];
        logic [7:0]  wd [$];
        gcyc = -1;
        dcyc = -1;
        rd   = 32'd0;
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_width = v.byte_w; ls_addr = v.addr; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 1; c <= 12 && dcyc < 0; c++) begin
            @(negedge clock);
            if (mem_we) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end
            if ((v.is_ls ? ls_gnt : if_gnt) && gcyc < 0) gcyc = c;
            if (v.is_ls ? ls_done : if_done) begin
                dcyc = c;
                rd   = v.is_ls ? ls_rdata : if_rdata;
                ls_req = 1'b0;
                if_req = 1'b0;
            end else if (gcyc > 0) begin
                // request fields change after grant; the transfer must not notice
                ls_addr = ~v.addr; ls_wdata = ~v.wdata; if_addr = ~v.addr;
            end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        chk($sformatf("v%0d gnt_cycle", idx), 32'(gcyc), 32'd1);
        chk($sformatf("v%0d done_cycle", idx), 32'(dcyc), 32'(v.lat));
        if (!v.we) chk($sformatf("v%0d rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d n_writes", idx), 32'(wa.size()), 32'(v.nwr));
        for (int k = 0; k < v.nwr && k < wa.size(); k++) begin
            chk($sformatf("v%0d waddr%0d", idx, k), wa[k], v.addr + 32'(k));
            chk($sformatf("v%0d wbyte%0d", idx, k), 32'(wd[k]), 32'(v.wdata[8*k +: 8]));
        end
        @(negedge clock);
    endtask

    // reference model state for the randomized run
    logic [7:0]  ref_mem [256];
    bit          m_last_ls, t_act, t_ls, t_we, t_byte, win, in_beat, is_done, seen;
    int          t_s, t_nb, next_arb, k, nm, ng, lsd;
    logic [31:0] t_addr, t_wdata, t_rd, e_if_rd, e_ls_rd, ord;
    logic [7:0]  bidx;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        if_req = 0; ls_req = 0; ls_we = 0; ls_width = 0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
        fp_if_req = 0; fp_ls_req = 0; fp_ls_we = 0; fp_ls_width = 0;
        fp_if_addr = '0; fp_ls_addr = '0; fp_ls_wdata = '0;
        load_mem = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset gnts", {30'd0, if_gnt, ls_gnt}, 32'd0);
        chk("reset dones", {30'd0, if_done, ls_done}, 32'd0);
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset ls_rdata", ls_rdata, 32'd0);
        @(negedge clock); load_mem = 1'b0;
        @(negedge clock); resetn = 1'b1;
        @(negedge clock);

        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h10,       32'hA1B2C3D4, 32'h0,        5, 4};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h10,       32'h0,        32'hA1B2C3D4, 5, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h12,       32'h0,        32'h000000B2, 2, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h11223344, 32'h0,        5, 4};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0,        32'h11223344, 5, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h20,       32'hDEADBE5A, 32'h0,        2, 1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h20,       32'h0,        32'h0000005A, 2, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h13,       32'h0,
                    {init_byte(32'h16), init_byte(32'h15), init_byte(32'h14), 8'hA1}, 5, 0};
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset asserted during beat 2 of a word store
        ls_req = 1'b1; ls_we = 1'b1; ls_width = 1'b0; ls_addr = 32'h40; ls_wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clock);
        chk("abort beat2 addr", mem_addr, 32'h42);
        chk("abort beat2 we", 32'(mem_we), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort mem_we", 32'(mem_we), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort mem_addr", mem_addr, 32'd0);
        ls_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2; c++) begin @(negedge clock); if (ls_done) seen = 1'b1; end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin @(negedge clock); if (ls_done || busy) seen = 1'b1; end
        chk("abort no done/idle", 32'(seen), 32'd0);
        chk("abort byte0", 32'(mem[8'h40]), 32'h0D);
        chk("abort byte1", 32'(mem[8'h41]), 32'hF0);
        chk("abort byte2", 32'(mem[8'h42]), 32'(init_byte(32'h42)));
        chk("abort byte3", 32'(mem[8'h43]), 32'(init_byte(32'h43)));
        chk("abort ls_rdata", ls_rdata, 32'd0);

        // round-robin with both requesting continuously
        ls_req = 1'b1; ls_we = 1'b0; ls_width = 1'b0; ls_addr = 32'h10; if_req = 1'b1; if_addr = 32'h20;
        ord = 32'd0; ng = 0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clock);
            if (ls_gnt) begin ord = {ord[23:0], 8'h4C}; ng++; end
            if (if_gnt) begin ord = {ord[23:0], 8'h49}; ng++; end
            if ((ls_done || if_done) && ng >= 4) begin ls_req = 1'b0; if_req = 1'b0; seen = 1'b1; end
        end
        ls_req = 1'b0; if_req = 1'b0;
        chk("rr grant order", ord, 32'h4C494C49);
        chk("rr ls_rdata", ls_rdata, 32'hA1B2C3D4);
        @(negedge clock);

        // fixed priority: IF waits until LS stops asking
        fp_ls_req = 1'b1; fp_ls_addr = 32'h50; fp_if_req = 1'b1; fp_if_addr = 32'h30;
        ord = 32'd0; lsd = 0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clock);
            if (fp_ls_gnt) ord = {ord[23:0], 8'h4C};
            if (fp_if_gnt) ord = {ord[23:0], 8'h49};
            if (fp_ls_done) begin lsd++; if (lsd == 3) fp_ls_req = 1'b0; end
            if (fp_if_done) begin fp_if_req = 1'b0; seen = 1'b1; end
        end
        fp_ls_req = 1'b0; fp_if_req = 1'b0;
        chk("fp grant order", ord, 32'h4C4C4C49);
        chk("fp if_rdata", fp_if_rdata, 32'h0F0E0D0C);
        chk("fp ls_rdata", fp_ls_rdata, 32'h6F6E6D6C);

        // randomized run against the transaction-level model
        @(negedge clock); resetn = 1'b0; load_mem = 1'b1;
        @(negedge clock); load_mem = 1'b0;
        @(negedge clock); resetn = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        m_last_ls = 1'b0; t_act = 1'b0; t_ls = 1'b0; e_if_rd = 32'd0; e_ls_rd = 32'd0; next_arb = 0;
        t_s = 0; t_nb = 1; t_we = 1'b0; t_byte = 1'b0; t_addr = 32'd0; t_wdata = 32'd0; t_rd = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            k       = c - t_s;
            in_beat = t_act && (c >= t_s) && (c < t_s + t_nb);
            is_done = t_act && (c == t_s + t_nb);
            if (is_done) begin
                if (t_ls) e_ls_rd = t_rd;
                else      e_if_rd = t_rd;
            end
            chk("rand busy", 32'(busy), 32'(in_beat || is_done));
            chk("rand mem_we", 32'(mem_we), 32'(in_beat && t_we));
            if (in_beat) chk("rand mem_addr", mem_addr, t_addr + 32'(k));
            if (in_beat && t_we) chk("rand mem_wdata", 32'(mem_wdata), 32'(t_wdata[8*k +: 8]));
            chk("rand if_gnt", 32'(if_gnt), 32'(in_beat && k == 0 && !t_ls));
            chk("rand ls_gnt", 32'(ls_gnt), 32'(in_beat && k == 0 && t_ls));
            chk("rand if_done", 32'(if_done), 32'(is_done && !t_ls));
            chk("rand ls_done", 32'(ls_done), 32'(is_done && t_ls));
            chk("rand if_rdata", if_rdata, e_if_rd);
            chk("rand ls_rdata", ls_rdata, e_ls_rd);

            if (in_beat) begin
                if (t_ls) begin
                    ls_addr = $urandom; ls_wdata = $urandom;
                    if ($urandom_range(0, 7) == 0) ls_req = 1'b0;
                end else begin
                    if_addr = $urandom;
                    if ($urandom_range(0, 7) == 0) if_req = 1'b0;
                end
            end
            if (is_done) begin
                if (t_ls) ls_req = 1'b0;
                else      if_req = 1'b0;
                t_act = 1'b0;
            end
            if (!ls_req && !(t_act && t_ls) && $urandom_range(0, 2) == 0) begin
                ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_width = 1'($urandom_range(0, 1));
                ls_addr = $urandom; ls_wdata = $urandom;
            end
            if (!if_req && !(t_act && !t_ls) && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end

            if (c == next_arb) begin
                if (if_req || ls_req) begin
                    win = ls_req && (!if_req || !m_last_ls);
                    if (if_req && ls_req) m_last_ls = win;
                    t_act   = 1'b1;
                    t_s     = c + 1;
                    t_ls    = win;
                    t_we    = win && ls_we;
                    t_byte  = win && ls_width;
                    t_addr  = win ? ls_addr : if_addr;
                    t_wdata = win ? ls_wdata : 32'd0;
                    t_nb    = t_byte ? 1 : 4;
                    t_rd    = 32'd0;
                    for (int b = 0; b < t_nb; b++) begin
                        bidx = t_addr[7:0] + 8'(b);
                        if (t_we) ref_mem[bidx] = t_wdata[8*b +: 8];
                        else      t_rd[8*b +: 8] = ref_mem[bidx];
                    end
                    next_arb = c + t_nb + 2;
                end else begin
                    next_arb = c + 1;
                end
            end
            @(negedge clock);
        end
        ls_req = 1'b0; if_req = 1'b0;
        repeat (8) @(negedge clock);
        nm = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nm++;
        chk("rand final memory mismatches", 32'(nm), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequencer and arbiter in front of the byte-wide data memory.
- Shares the memory between two requesters: the instruction-fetch port (IF, word reads only) and the load/store port (LS, byte or word, read or write).
- Splits each word access into 4 little-endian byte beats (byte 0 at base address) and assembles the read data.
- Sits between the core's fetch/LSU stages and the memory block.

Parameters:
- ADDR_W, 32, width of all address ports and of the beat address adder.
- LS_FIXED_PRIO, 0, arbitration mode: 0 = round-robin between IF and LS; 1 = LS always wins a tie.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_done  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- ls_req  in  1  load/store request; held high until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_width  in  1  1 = byte, 0 = word (same encoding as memory width)
- ls_addr  in  ADDR_W  load/store byte address
- ls_wdata  in  32  store data; byte stores use [7:0]
- ls_gnt  out  1  one-cycle pulse: LS request accepted
- ls_done  out  1  one-cycle pulse: access complete; ls_rdata valid for loads
- ls_rdata  out  32  load data; byte loads zero-extended
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  8  byte write data
- mem_we  out  1  byte write enable
- mem_rdata  in  8  memory read byte, combinational from mem_addr
- busy  out  1  high in BEAT and DONE states

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE.
  - All outputs low/zero, including if_rdata, ls_rdata, mem_we and mem_addr.
  - last_winner = IF, so LS wins the first tie in round-robin mode.
  - An in-flight transfer aborts immediately: no done pulse, no further writes.
- FSM has three states: IDLE, BEAT, DONE.
- IDLE:
  - Arbitration happens here only, at the clock edge.
  - Only one request pending: that requester wins.
  - Both pending, LS_FIXED_PRIO = 1: LS wins.
  - Both pending, LS_FIXED_PRIO = 0: the requester other than last_winner wins, and last_winner is updated.
  - On a win, latch addr, we, width and wdata (IF: we = 0, width = word), clear beat_cnt, set nbeats (1 for byte, 4 for word), go to BEAT.
  - No request: stay in IDLE. mem_we = 0, mem_addr holds its last value.
- BEAT:
  - Winner's gnt is high during the first BEAT cycle only.
  - mem_addr = latched_addr + beat_cnt, modulo 2^ADDR_W; misaligned and wrap-around accesses are legal.
  - mem_we = latched_we. mem_wdata = latched_wdata byte[beat_cnt].
  - Loads capture mem_rdata into assembly byte[beat_cnt] at the clock edge; assembly is cleared at grant.
  - beat_cnt increments each cycle. After beat nbeats-1, go to DONE.
- DONE:
  - One cycle. mem_we = 0.
  - The winner's done pulses; its rdata register is updated from the assembly (upper bytes zero for byte loads) at this edge and then holds until the next completion for that port.
  - Next state is IDLE.
- Latency from req sampled in IDLE at edge 0:
  - Byte access: gnt in cycle 1, done in cycle 2.
  - Word access: gnt in cycle 1, beats in cycles 1-4, done in cycle 5.
  - Minimum one IDLE cycle between transactions.
- Requester rules:
  - A requester drops req in its done cycle.
  - A req still high in the following IDLE cycle is a new request.
  - req deasserting mid-transfer is ignored; the transfer completes.
  - Changes to the request's addr/data after grant are ignored.
- The losing requester's req is only re-evaluated in IDLE. It sees no gnt until it wins.

Test Plan:
- Reset, then LS word store: ls_addr = 0x10, ls_wdata = 0xA1B2C3D4 -> mem_we high for 4 cycles at addresses 0x10..0x13 with bytes D4, C3, B2, A1; ls_done in cycle 5.
- IF word fetch at 0x10 after the store above -> if_rdata = 0xA1B2C3D4, if_done in cycle 5, mem_we low throughout.
- LS byte load at 0x12 -> exactly one beat; ls_rdata = 0x000000B2; ls_done in cycle 2.
- Both requesting continuously with LS_FIXED_PRIO = 0 -> grants alternate LS, IF, LS, IF. With LS_FIXED_PRIO = 1 -> IF is granted only after ls_req drops.
- Word store at 0xFFFFFFFE -> beat addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- resetn asserted during beat 2 of a word store -> mem_we low immediately; no ls_done; bytes 2-3 unwritten; FSM in IDLE after release.
